fp32_to_int32_seq: RTL

- Iterative IEEE-754 binary32 to signed 32-bit integer converter.
- Shifts the mantissa one bit per clock and adds a valid/ready handshake on both sides.
- Serves as the float-to-int return path of the typecast library: results from float datapaths go back into integer pipelines.
- Variable latency, area-minimal, one conversion in flight.

---
 rtl/fp32_to_int32_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fp32_to_int32_seq.sv
// Iterative IEEE-754 binary32 to int32 converter that shifts the mantissa one bit per clock.
// Optional macro FLOAT2INT_ROUND_NEAREST_EN selects round-to-nearest-even; default truncates toward zero.
module fp32_to_int32_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_DATA,
    output logic [2:0]  OUT_FLAGS
);
    typedef enum logic [2:0] {IDLE, DECODE, SHIFT, ROUND, DONE} state_t;

    state_t      state_q;
    logic [31:0] operand_q;
    logic [31:0] mag_q;
    logic        guard_q;
    logic        sticky_q;
    logic        shiftLeft_q;
    logic [4:0]  count_q;
    logic        outValid_q;
    logic [31:0] outData_q;
    logic [2:0]  outFlags_q;

    logic        sign;
    logic [7:0]  expField;
    logic [22:0] frac;
    logic        fracNonZero;
    logic        isNan;
    logic        isHuge;
    logic        isMinInt;
    logic        isTiny;
    logic [4:0]  expUnbiased;
    logic        isRight;
    logic [4:0]  shiftCount_d;
    logic        roundUp;
    logic [31:0] roundedMag_d;
    logic [31:0] result_d;
    logic [2:0]  flags_d;

    assign sign        = operand_q[31];
    assign expField    = operand_q[30:23];
    assign frac        = operand_q[22:0];
    assign fracNonZero = |frac;
    assign isNan       = (expField == 8'hFF) && fracNonZero;
    assign isHuge      = (expField >= 8'd158);
    assign isMinInt    = (operand_q == 32'hCF00_0000);
    assign isTiny      = (expField < 8'd127);

    // Only exponents 0..30 reach the shifter, so the low five bits of exp-127 are enough.
    assign expUnbiased  = expField[4:0] - 5'd31;
    assign isRight      = (expUnbiased < 5'd23);
    assign shiftCount_d = isRight ? (5'd23 - expUnbiased) : (expUnbiased - 5'd23);

`ifdef FLOAT2INT_ROUND_NEAREST_EN
    assign roundUp = guard_q & (sticky_q | mag_q[0]);
`else
    assign roundUp = 1'b0;
`endif

    assign roundedMag_d = mag_q + {31'd0, roundUp};

    always_comb begin
        result_d = sign ? (32'd0 - roundedMag_d) : roundedMag_d;
        flags_d  = {2'b00, guard_q | sticky_q};
        if (isNan) begin
            result_d = 32'h8000_0000;
            flags_d  = 3'b100;
        end else if (isHuge) begin
            result_d = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            flags_d  = isMinInt ? 3'b000 : 3'b010;
        end
    end

    // Magnitudes below one are folded into guard/sticky so ROUND treats them like any other operand.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            operand_q   <= 32'd0;
            mag_q       <= 32'd0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            shiftLeft_q <= 1'b0;
            count_q     <= 5'd0;
            outValid_q  <= 1'b0;
            outData_q   <= 32'd0;
            outFlags_q  <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        operand_q <= IN_DATA;
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    mag_q       <= 32'd0;
                    guard_q     <= 1'b0;
                    sticky_q    <= 1'b0;
                    shiftLeft_q <= 1'b0;
                    count_q     <= 5'd0;
                    state_q     <= ROUND;
                    if (!isNan && !isHuge) begin
                        if (isTiny) begin
                            guard_q  <= (expField == 8'd126);
                            sticky_q <= (expField == 8'd126) ? fracNonZero : ((expField != 8'd0) || fracNonZero);
                        end else begin
                            mag_q       <= {8'd0, 1'b1, frac};
                            shiftLeft_q <= !isRight;
                            count_q     <= shiftCount_d;
                            if (shiftCount_d != 5'd0) begin
                                state_q <= SHIFT;
                            end
                        end
                    end
                end
                SHIFT: begin
                    if (shiftLeft_q) begin
                        mag_q <= mag_q << 1;
                    end else begin
                        mag_q    <= mag_q >> 1;
                        guard_q  <= mag_q[0];
                        sticky_q <= sticky_q | guard_q;
                    end
                    count_q <= count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    outData_q  <= result_d;
                    outFlags_q <= flags_d;
                    outValid_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (OUT_READY) begin
                        outValid_q <= 1'b0;
                        outFlags_q <= 3'b000;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IN_READY  = (state_q == IDLE) && !RST;
    assign OUT_VALID = outValid_q;
    assign OUT_DATA  = outData_q;
    assign OUT_FLAGS = outFlags_q;
endmodule
